// File: rtl/seq_pkg.sv
// seq_pkg: state encoding and default counter width shared by the echo sequencer.
package seq_pkg;
    typedef enum logic [2:0] {IDLE, DEAD, PI2, TAU1, PI, TAU2, RABI, DONE} state_t;
    localparam int SEQ_CNT_W = 32;
endpackage

// File: rtl/trig_edge.sv
// trig_edge: rising-edge detector on a trigger input.
// With SEQ_TRIG_SYNC_EN defined, a 2-flop synchronizer precedes the detector.
module trig_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_rise
);
    logic w_s;
    logic r_prev;
`ifdef SEQ_TRIG_SYNC_EN
    logic [1:0] r_sync;
    always_ff @(posedge clk or posedge rst)
        if (rst) r_sync <= '0;
        else     r_sync <= {r_sync[0], i_d};
    assign w_s = r_sync[1];
`else
    assign w_s = i_d;
`endif
    always_ff @(posedge clk or posedge rst)
        if (rst) r_prev <= 1'b0;
        else     r_prev <= w_s;
    assign o_rise = w_s & ~r_prev;
endmodule

// File: rtl/echo_sequencer.sv
// echo_sequencer: dead time followed by a pi/2-tau-pi-tau echo train or a single Rabi pulse.
// Optional macro SEQ_TRIG_SYNC_EN synchronizes both trigger inputs (+2 cycles latency).
module echo_sequencer
    import seq_pkg::*;
#(
    parameter int CNT_W    = SEQ_CNT_W,
    parameter int DEAD_CNT = 333
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig,
    input  logic             rabi_trig,
    input  logic [CNT_W-1:0] pi2_len,
    input  logic [CNT_W-1:0] tau_len,
    input  logic [CNT_W-1:0] rabi_len,
    output logic             rf,
    output logic             rabi,
    output logic             busy,
    output logic             done
);
    typedef logic [CNT_W:0] cnt_t;
    localparam cnt_t DEAD_LD = cnt_t'(DEAD_CNT > 0 ? DEAD_CNT - 1 : 0);

    state_t           r_state, w_next;
    cnt_t             r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_pi2, r_tau, r_rabi_len, w_pi2_c;
    logic             r_echo, r_rf, r_rabi, r_busy, r_done;
    logic             w_trig_rise, w_rabi_rise, w_start, w_last;

    trig_edge u_trig_edge (.clk(clk), .rst(rst), .i_d(trig),      .o_rise(w_trig_rise));
    trig_edge u_rabi_edge (.clk(clk), .rst(rst), .i_d(rabi_trig), .o_rise(w_rabi_rise));

    // Counter holds remaining cycles minus one; a zero length still lasts one cycle.
    function automatic cnt_t ld(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : {1'b0, len} - cnt_t'(1);
    endfunction

    assign w_start = w_trig_rise | w_rabi_rise;
    assign w_last  = (r_cnt == '0);
    assign w_pi2_c = (r_pi2 == '0) ? CNT_W'(1) : r_pi2;

    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = r_cnt - cnt_t'(1);
        case (r_state)
            IDLE: begin
                w_next    = w_start ? DEAD : IDLE;
                w_cnt_nxt = w_start ? DEAD_LD : '0;
            end
            DEAD: if (w_last) begin
                w_next    = r_echo ? PI2 : RABI;
                w_cnt_nxt = r_echo ? ld(r_pi2) : ld(r_rabi_len);
            end
            PI2: if (w_last) begin
                w_next    = TAU1;
                w_cnt_nxt = ld(r_tau);
            end
            TAU1: if (w_last) begin
                w_next    = PI;
                w_cnt_nxt = {w_pi2_c, 1'b0} - cnt_t'(1);
            end
            PI: if (w_last) begin
                w_next    = TAU2;
                w_cnt_nxt = ld(r_tau);
            end
            TAU2, RABI: if (w_last) begin
                w_next    = DONE;
                w_cnt_nxt = '0;
            end
            default: begin
                w_next    = IDLE;
                w_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
        end

    // Lengths are captured at the detection edge; trig wins a tie with rabi_trig.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_pi2      <= '0;
            r_tau      <= '0;
            r_rabi_len <= '0;
            r_echo     <= 1'b0;
            r_rf       <= 1'b0;
            r_rabi     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            if (r_state == IDLE && w_start) begin
                r_pi2      <= pi2_len;
                r_tau      <= tau_len;
                r_rabi_len <= rabi_len;
                r_echo     <= w_trig_rise;
            end
            r_rf   <= (r_state == PI2) || (r_state == PI);
            r_rabi <= (r_state == RABI);
            r_busy <= (r_state != IDLE);
            r_done <= (r_state == DONE);
        end

    assign rf   = r_rf;
    assign rabi = r_rabi;
    assign busy = r_busy;
    assign done = r_done;
endmodule

// File: doc/echo_sequencer.md
ECHO_SEQUENCER -- requirements
Module: echo_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 32, meaning the width of all length inputs and of the internal counter.
REQ-002 SHALL have parameter DEAD_CNT, default 333, meaning the dead-time length in clk cycles before any pulse.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port trig, input, 1 bit: echo-sequence request, acting on its rising edge.
REQ-006 SHALL have port rabi_trig, input, 1 bit: Rabi-pulse request, acting on its rising edge.
REQ-007 SHALL have port pi2_len, input, CNT_W bits: pi/2 pulse length in cycles.
REQ-008 SHALL have port tau_len, input, CNT_W bits: free-precession interval in cycles.
REQ-009 SHALL have port rabi_len, input, CNT_W bits: Rabi pulse length in cycles.
REQ-010 SHALL have port rf, output, 1 bit: RF gate for the echo pulses.
REQ-011 SHALL have port rabi, output, 1 bit: RF gate for the Rabi pulse.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle completion strobe.

Function
REQ-014 SHALL implement the states IDLE, DEAD, PI2, TAU1, PI, TAU2, RABI and DONE.
REQ-015 SHALL treat the detection edge as the clk edge that samples trig or rabi_trig high after a low sample; this edge is cycle 0 and moves the FSM from IDLE to DEAD.
REQ-016 SHALL stay in DEAD for DEAD_CNT cycles, then go to PI2 for an echo request or RABI for a Rabi request.
REQ-017 SHALL run the echo path as PI2 for pi2_len cycles, TAU1 for tau_len, PI for 2*pi2_len, TAU2 for tau_len, then DONE for 1 cycle, then IDLE.
REQ-018 SHALL run the Rabi path as RABI for rabi_len cycles, then DONE for 1 cycle, then IDLE.
REQ-019 SHALL compute the PI length in CNT_W+1 bits, with no overflow.
REQ-020 SHALL sample pi2_len, tau_len and rabi_len into registers at the detection edge; later input changes do not affect a running sequence.
REQ-021 SHALL treat any length equal to zero as one cycle.
REQ-022 SHALL drive rf=1 exactly in PI2 and PI, and rf=0 otherwise.
REQ-023 SHALL drive rabi=1 exactly in RABI, and rabi=0 otherwise; rf and rabi are never high together.
REQ-024 SHALL drive done=1 exactly in DONE.
REQ-025 SHALL drive all outputs from registers, with no combinational path from any input to any output.
REQ-026 SHALL grant trig when rising edges of trig and rabi_trig coincide; the rabi_trig edge is discarded.
REQ-027 SHALL ignore trigger edges while busy=1, including during DONE; edges are not queued.

Reset
REQ-028 SHALL, on rst=1 at any time, immediately force state=IDLE, rf=0, rabi=0, busy=0, done=0, counter=0 and the latched lengths to 0.
REQ-029 SHALL reset the trigger history registers to 0, so a trigger held high through reset release counts as an edge on the first clk after release.
REQ-030 SHALL have no effect on a sequence interrupted by reset; the interrupted sequence never resumes.

Configuration
REQ-031 SHALL, when macro SEQ_TRIG_SYNC_EN is defined, pass trig and rabi_trig through a 2-flop synchronizer before edge detection, adding exactly 2 cycles of detection latency.
REQ-032 SHALL, when SEQ_TRIG_SYNC_EN is undefined, detect edges directly on the inputs, which are then required to be synchronous to clk.

Structure
REQ-033 SHALL take the state enumeration and the default CNT_W from a shared package seq_pkg.
REQ-034 SHALL contain sub-module trig_edge (optional synchronizer plus rising-edge detector), instantiated once per trigger input.

Verification
All scenarios use DEAD_CNT=5 and SEQ_TRIG_SYNC_EN undefined unless stated.
REQ-035 SHALL cover: pi2_len=3, tau_len=10, trig edge at cycle 0 -> rf=1 in cycles 6-8 and 19-24, rf=0 elsewhere, done=1 at cycle 35, busy=1 in cycles 1-35.
REQ-036 SHALL cover: rabi_len=4, rabi_trig edge at cycle 0 -> rabi=1 in cycles 6-9, rf stays 0, done=1 at cycle 10.
REQ-037 SHALL cover: trig and rabi_trig rising together -> the echo sequence of REQ-035 runs, rabi never rises, exactly one done.
REQ-038 SHALL cover: second trig edge at cycle 20, plus pi2_len changed to 7 at cycle 2 -> timing identical to REQ-035, exactly one done.
REQ-039 SHALL cover: rst=1 at cycle 21 (inside PI) -> rf=0 and busy=0 before the next clk edge; after release a fresh trig gives the REQ-035 timing relative to its new edge.
REQ-040 SHALL cover: pi2_len=0 with SEQ_TRIG_SYNC_EN defined -> rf=1 for 1 cycle, then 2 cycles, with the whole sequence shifted by 2 cycles versus the unsynchronized build.
